// File: rtl/rf_pulse_pkg.sv
// Shared definitions for the multi-channel edge-to-pulse generator.
//   mode_e          : per-channel edge selection (off / rise / fall / both)
//   DEF_SYNC_STAGES : default depth of the input synchroniser chain
package rf_pulse_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/rf_edge_pulse_ch.sv
// One channel of the edge-to-pulse generator: synchroniser, stability
// filter, qualified edge detector and pulse-length counter.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   signal_i      : raw asynchronous level
//   mode_i        : edge select (rf_pulse_pkg::mode_e encoding)
//   filt_len_i    : extra stable cycles needed before the filtered level moves
//   plen_i        : pulse length in cycles (0 behaves as 1)
//   clr_i         : clears the sticky miss flag
//   pulse_o       : registered output pulse
//   level_o       : filtered, synchronised level
//   miss_o        : sticky flag, an edge was dropped during a running pulse
module rf_edge_pulse_ch
  import rf_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = 4,
  parameter int PULSE_W     = 8,
  parameter int RETRIG      = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               signal_i,
  input  logic [1:0]         mode_i,
  input  logic [FILT_W-1:0]  filt_len_i,
  input  logic [PULSE_W-1:0] plen_i,
  input  logic               clr_i,
  output logic               pulse_o,
  output logic               level_o,
  output logic               miss_o
);

  localparam logic [PULSE_W-1:0] P_ONE = PULSE_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [FILT_W-1:0]      r_cnt;
  logic                   r_evt;
  logic [PULSE_W-1:0]     r_pcnt;
  logic                   r_pulse;
  logic                   r_miss;

  logic                   w_sync_q;
  logic                   w_filt_d;
  logic [FILT_W-1:0]      w_cnt_d;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_evt;
  mode_e                  w_mode;
  logic [PULSE_W-1:0]     w_plen_eff;
  logic                   w_busy;
  logic [PULSE_W-1:0]     w_pcnt_d;
  logic                   w_miss_set;
  logic                   w_miss_d;

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_mode   = mode_e'(mode_i);

  // Filter: the counter tracks how many consecutive cycles the synchronised
  // level has disagreed with the filtered one; it resets on agreement.
  always_comb begin
    w_filt_d = r_filt;
    w_cnt_d  = '0;
    if (w_sync_q != r_filt) begin
      if (r_cnt == filt_len_i) begin
        w_filt_d = w_sync_q;
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
  end

  // Edge is detected on the cycle the filtered level is about to change and
  // qualified by the mode seen in that same cycle.
  assign w_rise = w_filt_d & ~r_filt;
  assign w_fall = ~w_filt_d & r_filt;

  always_comb begin
    w_evt = 1'b0;
    case (w_mode)
      MODE_RISE: w_evt = w_rise;
      MODE_FALL: w_evt = w_fall;
      MODE_BOTH: w_evt = w_rise | w_fall;
      default:   w_evt = 1'b0;
    endcase
  end

  // Pulse counter. A count of 1 is the final high cycle, so an event there
  // reloads directly and the next pulse follows with no low gap.
  assign w_plen_eff = (plen_i == '0) ? P_ONE : plen_i;
  assign w_busy     = (r_pcnt > P_ONE);
  assign w_miss_set = (RETRIG == 0) && r_evt && w_busy;

  always_comb begin
    w_pcnt_d = (r_pcnt != '0) ? (r_pcnt - P_ONE) : '0;
    if (r_evt && (!w_busy || (RETRIG != 0))) begin
      w_pcnt_d = w_plen_eff;
    end
  end

  // A new miss wins over a simultaneous clear.
  always_comb begin
    w_miss_d = r_miss;
    if (w_miss_set) begin
      w_miss_d = 1'b1;
    end else if (clr_i) begin
      w_miss_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync  <= '0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
      r_evt   <= 1'b0;
      r_pcnt  <= '0;
      r_pulse <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_sync[0] <= signal_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_filt  <= w_filt_d;
      r_cnt   <= w_cnt_d;
      r_evt   <= w_evt;
      r_pcnt  <= w_pcnt_d;
      r_pulse <= (w_pcnt_d != '0);
      r_miss  <= w_miss_d;
    end
  end

  assign pulse_o = r_pulse;
  assign level_o = r_filt;
  assign miss_o  = r_miss;

endmodule

// File: rtl/rf_edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator: NUM_CH independent channels, each
// turning qualified edges of a deglitched asynchronous level into pulses of
// programmable length.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   signal_i      : raw levels, one bit per channel
//   mode_i        : 2 bits per channel, 00 off / 01 rise / 10 fall / 11 both
//   filt_len_i    : FILT_W bits per channel, filter length
//   plen_i        : PULSE_W bits per channel, pulse length (0 behaves as 1)
//   clr_i         : per-channel miss clear
//   pulse_o       : per-channel pulses
//   level_o       : per-channel filtered level
//   miss_o        : per-channel sticky dropped-edge flag (RETRIG=0 only)
module rf_edge_pulse_gen
  import rf_pulse_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = 4,
  parameter int PULSE_W     = 8,
  parameter int RETRIG      = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CH-1:0]         signal_i,
  input  logic [2*NUM_CH-1:0]       mode_i,
  input  logic [FILT_W*NUM_CH-1:0]  filt_len_i,
  input  logic [PULSE_W*NUM_CH-1:0] plen_i,
  input  logic [NUM_CH-1:0]         clr_i,
  output logic [NUM_CH-1:0]         pulse_o,
  output logic [NUM_CH-1:0]         level_o,
  output logic [NUM_CH-1:0]         miss_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rf_edge_pulse_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W),
      .PULSE_W     (PULSE_W),
      .RETRIG      (RETRIG)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .signal_i   (signal_i[c]),
      .mode_i     (mode_i[2*c +: 2]),
      .filt_len_i (filt_len_i[FILT_W*c +: FILT_W]),
      .plen_i     (plen_i[PULSE_W*c +: PULSE_W]),
      .clr_i      (clr_i[c]),
      .pulse_o    (pulse_o[c]),
      .level_o    (level_o[c]),
      .miss_o     (miss_o[c])
    );
  end

endmodule

// File: tb/tb_rf_edge_pulse_gen.sv
// Bench for rf_edge_pulse_gen. Two instances share one set of inputs: one
// built with retriggering, one without. A behavioural model predicts every
// output after every clock edge; directed phases follow the test plan and a
// randomized phase follows.
module tb_rf_edge_pulse_gen;

  localparam int NUM_CH  = 4;
  localparam int SYNC    = 2;
  localparam int FILT_W  = 4;
  localparam int PULSE_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]         sig;
  logic [2*NUM_CH-1:0]       mode;
  logic [FILT_W*NUM_CH-1:0]  filt_len;
  logic [PULSE_W*NUM_CH-1:0] plen;
  logic [NUM_CH-1:0]         clr;
  logic [NUM_CH-1:0]         pulse_r, level_r, miss_r;
  logic [NUM_CH-1:0]         pulse_n, level_n, miss_n;

  rf_edge_pulse_gen #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .FILT_W(FILT_W),
                      .PULSE_W(PULSE_W), .RETRIG(1)) u_dut_r (
    .clk_i(clk), .rst_ni(rst_n), .signal_i(sig), .mode_i(mode),
    .filt_len_i(filt_len), .plen_i(plen), .clr_i(clr),
    .pulse_o(pulse_r), .level_o(level_r), .miss_o(miss_r)
  );

  rf_edge_pulse_gen #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .FILT_W(FILT_W),
                      .PULSE_W(PULSE_W), .RETRIG(0)) u_dut_n (
    .clk_i(clk), .rst_ni(rst_n), .signal_i(sig), .mode_i(mode),
    .filt_len_i(filt_len), .plen_i(plen), .clr_i(clr),
    .pulse_o(pulse_n), .level_o(level_n), .miss_o(miss_n)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;  // edge index since last reset release

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n - 1);
    end
  endtask

  // ---------------- reference model ----------------
  // sh_q   : raw samples not yet through the synchroniser
  // win_q  : recent synchronised values, used to test "stable long enough"
  // m_last : index of the last edge after which the pulse is still high
  bit sh_q  [NUM_CH][$];
  bit win_q [NUM_CH][$];
  bit m_filt[NUM_CH];
  bit m_pend[NUM_CH];
  int m_last[2][NUM_CH];
  bit m_miss[2][NUM_CH];
  logic [5*NUM_CH-1:0] exp_q[$];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      sh_q[c].delete();
      win_q[c].delete();
      m_filt[c] = 1'b0;
      m_pend[c] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_last[k][c] = -1;
        m_miss[k][c] = 1'b0;
      end
    end
    exp_q.delete();
    n = 0;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] e_pr, e_pn, e_lv, e_mr, e_mn;
    for (int c = 0; c < NUM_CH; c++) begin
      int p, fl;
      bit cur, stable, rose, set_m;
      logic [1:0] m;
      // pulse start for an edge seen one clock earlier
      p = int'(plen[c*PULSE_W +: PULSE_W]);
      if (p == 0) p = 1;
      for (int k = 0; k < 2; k++) begin
        set_m = 1'b0;
        if (m_pend[c]) begin
          // k==0 retriggers; k==1 only starts when the old pulse ends by now
          if (k == 0 || m_last[k][c] < n) m_last[k][c] = n + p - 1;
          else set_m = 1'b1;
        end
        if (set_m) m_miss[k][c] = 1'b1;
        else if (clr[c]) m_miss[k][c] = 1'b0;
      end
      // filtered level follows once the synchronised level has held the
      // opposite value for filt_len+1 consecutive edges
      cur = (sh_q[c].size() == SYNC) ? sh_q[c][0] : 1'b0;
      win_q[c].push_back(cur);
      if (win_q[c].size() > 16) void'(win_q[c].pop_front());
      fl = int'(filt_len[c*FILT_W +: FILT_W]);
      stable = (win_q[c].size() >= fl + 1);
      if (stable) begin
        for (int i = 0; i <= fl; i++) begin
          if (win_q[c][win_q[c].size() - 1 - i] == m_filt[c]) stable = 1'b0;
        end
      end
      m_pend[c] = 1'b0;
      if (stable) begin
        rose = !m_filt[c];
        m_filt[c] = rose;
        m = mode[2*c +: 2];
        m_pend[c] = rose ? m[0] : m[1];
      end
      sh_q[c].push_back(sig[c]);
      if (sh_q[c].size() > SYNC) void'(sh_q[c].pop_front());
      e_pr[c] = (n <= m_last[0][c]);
      e_pn[c] = (n <= m_last[1][c]);
      e_lv[c] = m_filt[c];
      e_mr[c] = m_miss[0][c];
      e_mn[c] = m_miss[1][c];
    end
    exp_q.push_back({e_lv, e_pr, e_pn, e_mr, e_mn});
    n++;
  endtask

  task automatic compare_outputs();
    logic [5*NUM_CH-1:0] e;
    e = exp_q.pop_front();
    check_eq("level_r", 32'(level_r), 32'(e[4*NUM_CH +: NUM_CH]));
    check_eq("level_n", 32'(level_n), 32'(e[4*NUM_CH +: NUM_CH]));
    check_eq("pulse_r", 32'(pulse_r), 32'(e[3*NUM_CH +: NUM_CH]));
    check_eq("pulse_n", 32'(pulse_n), 32'(e[2*NUM_CH +: NUM_CH]));
    check_eq("miss_r",  32'(miss_r),  32'(e[1*NUM_CH +: NUM_CH]));
    check_eq("miss_n",  32'(miss_n),  32'(e[0 +: NUM_CH]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic set_all(input logic [1:0] m, input int fl, input int pl);
    for (int c = 0; c < NUM_CH; c++) begin
      mode[2*c +: 2]                = m;
      filt_len[c*FILT_W +: FILT_W]  = FILT_W'(fl);
      plen[c*PULSE_W +: PULSE_W]    = PULSE_W'(pl);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt_a, cnt_b, cnt_c;
    sig = '0; clr = '0;
    set_all(2'b01, 0, 1);
    repeat (3) @(negedge clk);
    check_eq("rst_pulse_r", 32'(pulse_r), 32'(0));
    check_eq("rst_pulse_n", 32'(pulse_n), 32'(0));
    check_eq("rst_level",   32'(level_r), 32'(0));
    check_eq("rst_miss_n",  32'(miss_n),  32'(0));
    model_reset();
    rst_n = 1'b1;

    // latency: rise mode, no filter, 1-cycle pulse
    for (int k = 0; k < 20; k++) begin
      sig = (k < 10) ? '1 : '0;
      cycle();
      if (k == 1) check_eq("lat_level_e1", 32'(level_r[0]), 32'(0));
      if (k == 2) check_eq("lat_level_e2", 32'(level_r[0]), 32'(1));
      if (k == 2) check_eq("lat_pulse_e2", 32'(pulse_r[0]), 32'(0));
      if (k == 3) check_eq("lat_pulse_e3", 32'(pulse_r[0]), 32'(1));
      if (k == 4) check_eq("lat_pulse_e4", 32'(pulse_r[0]), 32'(0));
    end

    // filter: 3-cycle glitch rejected, 4-cycle pulse accepted
    set_all(2'b11, 3, 1);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 40; k++) begin
      sig = ((k >= 10 && k < 13) || (k >= 20 && k < 24)) ? '1 : '0;
      cycle();
      cnt_a += int'(level_r[0]);
      cnt_b += int'(pulse_r[0]);
    end
    check_eq("filt_level_cycles", 32'(cnt_a), 32'(4));
    check_eq("filt_pulse_cycles", 32'(cnt_b), 32'(2));

    // stretch and plen=0
    set_all(2'b01, 0, 0);
    plen[0*PULSE_W +: PULSE_W] = 8'd5;
    plen[2*PULSE_W +: PULSE_W] = 8'd3;
    plen[3*PULSE_W +: PULSE_W] = 8'd2;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 24; k++) begin
      sig = (k >= 2 && k < 12) ? '1 : '0;
      cycle();
      cnt_a += int'(pulse_r[0]);
      cnt_b += int'(pulse_r[1]);
    end
    check_eq("plen5_cycles", 32'(cnt_a), 32'(5));
    check_eq("plen0_cycles", 32'(cnt_b), 32'(1));

    // retrigger versus drop, clear priority
    set_all(2'b11, 0, 8);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 36; k++) begin
      sig = (k < 3 || (k >= 16 && k < 21)) ? '1 : '0;
      clr = (k == 24 || k == 30) ? '1 : '0;
      cycle();
      if (k < 16) begin
        cnt_a += int'(pulse_r[0]);
        cnt_b += int'(pulse_n[0]);
      end
      if (k == 24) check_eq("miss_set_beats_clr", 32'(miss_n[0]), 32'(1));
      if (k == 30) check_eq("miss_cleared", 32'(miss_n[0]), 32'(0));
    end
    clr = '0;
    check_eq("retrig_cycles", 32'(cnt_a), 32'(11));
    check_eq("noretrig_cycles", 32'(cnt_b), 32'(8));

    // independence: ch0 off, ch1 fall, ch2 rise, ch3 both
    set_all(2'b00, 1, 2);
    mode = {2'b11, 2'b01, 2'b10, 2'b00};
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 40; k++) begin
      sig = ((k / 6) % 2 == 1) ? '1 : '0;
      cycle();
      cnt_a += int'(pulse_r[0]) + int'(pulse_n[0]);
      cnt_b += int'(level_r[0]);
    end
    check_eq("mode_off_pulses", 32'(cnt_a), 32'(0));
    check_eq("mode_off_level_tracks", 32'(cnt_b != 0), 32'(1));

    // randomized segments; each ends with a quiet hold so the filter settles
    // before its length is changed
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mode[2*c +: 2]               = 2'($urandom_range(0, 3));
        filt_len[c*FILT_W +: FILT_W] = FILT_W'($urandom_range(0, 6));
        plen[c*PULSE_W +: PULSE_W]   = PULSE_W'($urandom_range(0, 12));
      end
      for (int k = 0; k < 84; k++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (k < 60 && $urandom_range(0, 3) == 0) sig[c] = ~sig[c];
          clr[c] = ($urandom_range(0, 7) == 0);
        end
        cycle();
      end
    end
    clr = '0;

    // reset asserted in the middle of a running pulse
    set_all(2'b11, 0, 20);
    sig = ~sig;
    repeat (6) cycle();
    check_eq("pre_rst_pulse_r", 32'(pulse_r), 32'({NUM_CH{1'b1}}));
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_pulse_r", 32'(pulse_r), 32'(0));
    check_eq("async_rst_pulse_n", 32'(pulse_n), 32'(0));
    check_eq("async_rst_level",   32'(level_r), 32'(0));
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 30; k++) begin
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_edge_pulse_gen.md
Name: rf_edge_pulse_gen

Overview:
Multi-channel, parametrised edge-to-pulse generator and the successor of the single-channel rising-edge pulser.
- Each channel synchronises an asynchronous level, deglitches it with a programmable stability filter, and detects rising, falling or both edges per channel mode.
- On each detected edge it emits a registered pulse of programmable length, with a selectable retrigger policy.
- Sits between raw control/status pins and the control logic that consumes single-cycle or stretched strobes.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=1)
FILT_W, 4, width of filter length field and filter counter
PULSE_W, 8, width of pulse length field and pulse counter
RETRIG, 1, 1 = edge during active pulse reloads length (extends); 0 = edge ignored, miss flagged

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
signal_i  in  NUM_CH  raw input levels, one per channel, asynchronous to clk_i
mode_i  in  2*NUM_CH  per-channel edge select: 00 off, 01 rise, 10 fall, 11 both
filt_len_i  in  FILT_W*NUM_CH  per-channel extra stable cycles required before the filtered level changes
plen_i  in  PULSE_W*NUM_CH  per-channel pulse length in cycles; 0 treated as 1
clr_i  in  NUM_CH  per-channel clear of miss_o
pulse_o  out  NUM_CH  registered output pulses
level_o  out  NUM_CH  filtered, synchronised level (filt_q)
miss_o  out  NUM_CH  sticky: an edge was dropped (RETRIG=0 only)

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all synchroniser flops, filt_q, filter counter, pulse counter, pulse_o, level_o and miss_o are 0.
- Synchroniser: signal_i[c] passes through a SYNC_STAGES flop chain; sync_q is the last stage.
- Filter, evaluated every edge:
  - If sync_q != filt_q and cnt == filt_len_i[c]: filt_q <= sync_q and cnt <= 0.
  - Else if sync_q != filt_q: cnt <= cnt + 1.
  - Else: cnt <= 0.
  - filt_len 0 means no filtering. A glitch lasting <= filt_len cycles at sync_q never reaches filt_q.
- Edge event (combinational, internal): rise = filt_d & ~filt_q, fall = ~filt_d & filt_q, where filt_d is the value filt_q takes at the next edge.
  - The event is qualified by mode_i[c]; mode 00 masks all events.
  - The filter keeps tracking in mode 00.
- Pulse counter pcnt (PULSE_W bits), pulse_o = registered (pcnt_next != 0):
  - Event with pcnt <= 1 (idle or final cycle): pcnt <= max(plen,1). This gives back-to-back pulses with no low gap.
  - Event with pcnt > 1 and RETRIG=1: pcnt <= max(plen,1). The pulse is extended with no gap.
  - Event with pcnt > 1 and RETRIG=0: pcnt decrements normally and miss_o[c] <= 1.
  - No event: pcnt decrements while nonzero.
- Latency: with signal_i[c] first sampled high at edge E0 and a stable input, level_o rises after E(SYNC_STAGES+filt_len). pulse_o rises after E(SYNC_STAGES+filt_len+1) and stays high exactly max(plen,1) cycles.
- plen_i, filt_len_i and mode_i are sampled at the event cycle. Changing them mid-pulse does not alter a running pulse, and mode 00 does not abort it.
- miss_o: set has priority over clr_i in the same cycle. miss_o is constant 0 when RETRIG=0 is not configured.
- A high input at reset release is a rising edge: it produces a pulse in rise or both mode.
- Reset asserted mid-pulse clears all state immediately. No pulse resumes after release.
- Channels are fully independent, and no channel-to-channel ordering is guaranteed.

Decomposition:
- Package rf_pulse_pkg holds:
  - mode encodings MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11
  - a mode typedef
  - a helper constant for the default SYNC_STAGES
- One sub-module, rf_edge_pulse_ch, holds the single-channel sync, filter, edge detect and pulse counter logic. The top is a generate loop of NUM_CH instances that slices the packed config vectors.

Test Plan:
- Reset/latency (SYNC_STAGES=2, filt_len=0, plen=1, mode=01): signal_i[0] 0->1 sampled at E0 -> level_o[0] high after E2; pulse_o[0] high only in the cycle after E3; no pulse on 1->0.
- Filter (filt_len=3, mode=11): a 3-cycle high glitch produces no level_o change and no pulse. A 4-cycle high then low produces level_o high for 4 cycles and 2 pulses.
- Stretch and plen=0: plen=5 -> pulse_o exactly 5 cycles; plen=0 -> exactly 1 cycle.
- Retrigger (RETRIG=1, plen=8, mode=11, filt_len=0): toggle input 3 cycles after pulse start -> pulse_o continuous for 11 cycles total, miss_o stays 0.
- No retrigger (RETRIG=0, same stimulus): pulse_o is 8 cycles, miss_o[c] set. clr_i is pulsed while a new miss occurs the same cycle, and miss_o stays 1. clr_i is then pulsed alone, and miss_o returns to 0.
- Channel independence and mode off: ch0 mode 00 and ch1 mode 10, drive the same waveform -> ch0 never pulses but level_o[0] tracks. ch1 pulses only on falls. Assert rst_ni mid-pulse -> pulse_o clears asynchronously.
